// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the ethernet parser front-end.
//   arb_state_t      : port arbiter FSM state encoding
//   MAX_PARSER_PORTS : largest number of ingress ports a shared parser serves
package eth_parser_pkg;

    localparam int MAX_PARSER_PORTS = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

endpackage

// File: rtl/port_id_fifo.sv
// Synchronous FIFO holding the source port ID of each granted frame.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (flushes the FIFO)
//   push, din   : write request and data (ignored while full)
//   pop, dout   : read request and head-of-queue data (ignored while empty)
//   full, empty : occupancy flags
module port_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer is a wrap bit distinguishing full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/eth_parser_port_arbiter.sv
// Frame-atomic round-robin arbiter sharing one ethernet_frame_parser between
// NUM_PORTS AXI4-Stream ingress ports, with source-port tagging of metadata.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   s_axis_t{data,valid,last} : per-port ingress streams; s_axis_tready back
//   m_axis_t{data,valid,last} : muxed stream to the parser; m_axis_tready back
//   meta_valid                : parser metadata strobe (m_axis_tuser_valid)
//   meta_port_id(_valid)      : source port of the presented metadata
//   grant_port, busy          : current grant and GRANT-state indicator
//   id_fifo_full              : no more frames may be granted
//   id_underflow              : sticky, metadata seen with no frame pending
//
// state     | meaning
// ARB_IDLE  | no grant; arbitrate among valid ports, one cycle between frames
// ARB_GRANT | grant_port owns the parser until its tlast beat is accepted
module eth_parser_port_arbiter
    import eth_parser_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int DATA_WIDTH    = 64,
    parameter int ID_FIFO_DEPTH = 8,
    parameter int PORT_W        = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    input  logic                            meta_valid,
    output logic [PORT_W-1:0]               meta_port_id,
    output logic                            meta_port_id_valid,
    output logic [PORT_W-1:0]               grant_port,
    output logic                            busy,
    output logic                            id_fifo_full,
    output logic                            id_underflow
);

    arb_state_t  state;
    arb_state_t  state_nxt;
    logic [PORT_W-1:0] last_grant;
    logic [PORT_W-1:0] sel_port;
    logic        sel_found;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        frame_end;

    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] tdata_arr;

    assign tdata_arr = s_axis_tdata;
    assign busy      = (state == ARB_GRANT);

    // Cyclic search starting just after the last port to finish a frame.
    always_comb begin : sel_blk
        logic [PORT_W-1:0] idx;
        sel_found = 1'b0;
        sel_port  = '0;
        idx       = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = PORT_W'((int'(last_grant) + i) % NUM_PORTS);
            if (!sel_found && s_axis_tvalid[idx]) begin
                sel_found = 1'b1;
                sel_port  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (sel_found && !id_fifo_full) begin
                    push      = 1'b1;
                    state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (frame_end) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_port   <= '0;
            last_grant   <= PORT_W'(NUM_PORTS - 1);
            id_underflow <= 1'b0;
        end else begin
            if (push)                     grant_port   <= sel_port;
            if (frame_end)                last_grant   <= grant_port;
            if (meta_valid && fifo_empty) id_underflow <= 1'b1;
        end
    end

    // Zero-latency datapath; everything is gated off outside GRANT.
    assign m_axis_tdata  = tdata_arr[grant_port];
    assign m_axis_tvalid = busy & s_axis_tvalid[grant_port];
    assign m_axis_tlast  = busy & s_axis_tlast[grant_port];
    assign frame_end     = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin
        s_axis_tready = '0;
        if (busy) s_axis_tready[grant_port] = m_axis_tready;
    end

    assign pop                = meta_valid & ~fifo_empty;
    assign meta_port_id_valid = pop;

    port_id_fifo #(
        .WIDTH (PORT_W),
        .DEPTH (ID_FIFO_DEPTH)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (sel_port),
        .dout  (meta_port_id),
        .full  (id_fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_eth_parser_port_arbiter.sv
module tb_eth_parser_port_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int PW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP*DW-1:0] s_axis_tdata = '0;
    logic [NP-1:0]   s_axis_tvalid = '0;
    logic [NP-1:0]   s_axis_tready;
    logic [NP-1:0]   s_axis_tlast = '0;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic            m_axis_tlast;
    logic            meta_valid = 1'b0;
    logic [PW-1:0]   meta_port_id;
    logic            meta_port_id_valid;
    logic [PW-1:0]   grant_port;
    logic            busy;
    logic            id_fifo_full;
    logic            id_underflow;

    eth_parser_port_arbiter #(
        .NUM_PORTS     (NP),
        .DATA_WIDTH    (DW),
        .ID_FIFO_DEPTH (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tlast       (m_axis_tlast),
        .meta_valid         (meta_valid),
        .meta_port_id       (meta_port_id),
        .meta_port_id_valid (meta_port_id_valid),
        .grant_port         (grant_port),
        .busy               (busy),
        .id_fifo_full       (id_fifo_full),
        .id_underflow       (id_underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Source model state per port
    int frames_left [NP];
    int flen        [NP];
    int beat        [NP];
    int fidx        [NP];

    // Observation logs
    logic [DW-1:0] mlog [$];
    int            glog [$];
    int            gaps [$];
    int            nlast;
    int            last_pos;
    logic [NP-1:0] tready_seen;
    logic          prev_busy;
    int            idle_run;

    function automatic logic [DW-1:0] dval(int p, int f, int b);
        return DW'(p * 65536 + f * 256 + b);
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(int p, int n, int l);
        frames_left[p] = n;
        flen[p]        = l;
        beat[p]        = 0;
        fidx[p]        = 0;
    endtask

    task automatic drive_srcs();
        for (int p = 0; p < NP; p++) begin
            s_axis_tvalid[p] = (frames_left[p] > 0);
            s_axis_tlast[p]  = (frames_left[p] > 0) && (beat[p] == flen[p] - 1);
            s_axis_tdata[p*DW +: DW] = dval(p, fidx[p], beat[p]);
        end
    endtask

    task automatic clear_logs();
        mlog.delete();
        glog.delete();
        gaps.delete();
        nlast       = 0;
        last_pos    = 0;
        tready_seen = '0;
        prev_busy   = busy;
        idle_run    = 0;
    endtask

    task automatic tick();
        logic [NP-1:0] hs;
        hs = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
            mlog.push_back(m_axis_tdata);
            if (m_axis_tlast) begin
                nlast++;
                last_pos = mlog.size();
            end
        end
        tready_seen |= s_axis_tready;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) begin
                if (beat[p] == flen[p] - 1) begin
                    beat[p] = 0;
                    fidx[p]++;
                    frames_left[p]--;
                end else begin
                    beat[p]++;
                end
            end
        end
        drive_srcs();
        #1;
        if (busy && !prev_busy) begin
            if (glog.size() > 0) gaps.push_back(idle_run);
            glog.push_back(int'(grant_port));
            idle_run = 0;
        end else if (!busy) begin
            idle_run++;
        end
        prev_busy = busy;
    endtask

    task automatic do_reset();
        for (int p = 0; p < NP; p++) load(p, 0, 1);
        drive_srcs();
        meta_valid    = 1'b0;
        m_axis_tready = 1'b1;
        rst           = 1'b1;
        #1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        clear_logs();
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant_port), 64'd0);
        check("rst_full", 64'(id_fifo_full), 64'd0);
        check("rst_underflow", 64'(id_underflow), 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_meta_v", 64'(meta_port_id_valid), 64'd0);

        // ---------------- underflow ----------------
        meta_valid = 1'b1;
        #1;
        check("uf_meta_v", 64'(meta_port_id_valid), 64'd0);
        tick();
        meta_valid = 1'b0;
        #1;
        check("uf_set", 64'(id_underflow), 64'd1);
        tick();
        tick();
        check("uf_sticky", 64'(id_underflow), 64'd1);
        check("uf_meta_v_idle", 64'(meta_port_id_valid), 64'd0);

        // ---------------- single frame from port 2 ----------------
        do_reset();
        check("sf_uf_cleared", 64'(id_underflow), 64'd0);
        load(2, 1, 3);
        drive_srcs();
        #1;
        tick();
        check("sf_grant", 64'(grant_port), 64'd2);
        check("sf_busy", 64'(busy), 64'd1);
        check("sf_tready", 64'(s_axis_tready), 64'b0100);
        check("sf_data0", m_axis_tdata, dval(2, 0, 0));
        for (int c = 0; c < 10 && frames_left[2] > 0; c++) tick();
        check("sf_nbeats", 64'(mlog.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            if (i < mlog.size()) check($sformatf("sf_beat%0d", i), mlog[i], dval(2, 0, i));
        check("sf_nlast", 64'(nlast), 64'd1);
        check("sf_last_pos", 64'(last_pos), 64'd3);
        check("sf_idle_after", 64'(busy), 64'd0);
        meta_valid = 1'b1;
        #1;
        check("sf_meta_id", 64'(meta_port_id), 64'd2);
        check("sf_meta_v", 64'(meta_port_id_valid), 64'd1);
        tick();
        meta_valid = 1'b0;
        #1;
        check("sf_meta_drained", 64'(meta_port_id_valid), 64'd0);
        check("sf_no_uf", 64'(id_underflow), 64'd0);

        // ---------------- fairness ----------------
        do_reset();
        for (int p = 0; p < NP; p++) load(p, 2, 2);
        drive_srcs();
        #1;
        for (int c = 0; c < 60 && glog.size() < 5; c++) tick();
        check("fair_ngrants", 64'(glog.size() >= 5), 64'd1);
        for (int i = 0; i < 5; i++)
            if (i < glog.size()) check($sformatf("fair_order%0d", i), 64'(glog[i]), 64'(i % 4));
        for (int i = 0; i < 4; i++)
            if (i < gaps.size()) check($sformatf("fair_gap%0d", i), 64'(gaps[i]), 64'd1);
        check("fair_ngaps", 64'(gaps.size() >= 4), 64'd1);

        // ---------------- backpressure ----------------
        do_reset();
        load(1, 1, 5);
        drive_srcs();
        #1;
        for (int c = 0; c < 40 && frames_left[1] > 0; c++) begin
            m_axis_tready = (c % 2 == 0);
            #1;
            tick();
        end
        m_axis_tready = 1'b1;
        tick();
        check("bp_nbeats", 64'(mlog.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            if (i < mlog.size()) check($sformatf("bp_beat%0d", i), mlog[i], dval(1, 0, i));
        check("bp_tready_seen", 64'(tready_seen), 64'b0010);
        check("bp_nlast", 64'(nlast), 64'd1);
        meta_valid = 1'b1;
        #1;
        check("bp_meta_id", 64'(meta_port_id), 64'd1);
        tick();
        meta_valid = 1'b0;
        #1;

        // ---------------- FIFO full ----------------
        do_reset();
        for (int p = 0; p < NP; p++) load(p, 3, 1);
        drive_srcs();
        #1;
        for (int c = 0; c < 30; c++) tick();
        check("full_flag", 64'(id_fifo_full), 64'd1);
        check("full_ngrants", 64'(glog.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            if (i < glog.size()) check($sformatf("full_order%0d", i), 64'(glog[i]), 64'(i % 4));
        check("full_stalled", 64'(busy), 64'd0);
        meta_valid = 1'b1;
        #1;
        check("full_meta_id", 64'(meta_port_id), 64'd0);
        check("full_meta_v", 64'(meta_port_id_valid), 64'd1);
        tick();
        meta_valid = 1'b0;
        #1;
        check("full_cleared", 64'(id_fifo_full), 64'd0);
        check("full_still_idle", 64'(busy), 64'd0);
        tick();
        check("full_resume_busy", 64'(busy), 64'd1);
        check("full_resume_grant", 64'(grant_port), 64'd0);
        check("full_refull", 64'(id_fifo_full), 64'd1);

        // ---------------- reset mid-frame ----------------
        do_reset();
        load(3, 1, 4);
        drive_srcs();
        #1;
        tick();
        check("rmf_grant3", 64'(grant_port), 64'd3);
        load(0, 1, 2);
        drive_srcs();
        #1;
        tick();
        check("rmf_beat2", m_axis_tdata, dval(3, 0, 1));
        rst = 1'b1;
        #1;
        tick();
        check("rmf_busy", 64'(busy), 64'd0);
        check("rmf_grant", 64'(grant_port), 64'd0);
        check("rmf_tready", 64'(s_axis_tready), 64'd0);
        check("rmf_mvalid", 64'(m_axis_tvalid), 64'd0);
        check("rmf_full", 64'(id_fifo_full), 64'd0);
        check("rmf_meta_v", 64'(meta_port_id_valid), 64'd0);
        check("rmf_nlast", 64'(nlast), 64'd0);
        rst = 1'b0;
        #1;
        tick();
        check("rmf_after_busy", 64'(busy), 64'd1);
        check("rmf_after_grant", 64'(grant_port), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_parser_port_arbiter.md
Name: eth_parser_port_arbiter

Overview:
- Shares one ethernet_frame_parser instance between NUM_PORTS AXI4-Stream ingress ports.
- Arbitration is frame-atomic round-robin: a granted port keeps the parser until its tlast beat is accepted.
- Records the source port of every granted frame in an ID FIFO, and returns that port ID alongside each parser metadata pulse so downstream logic can attribute metadata to a port.
- Sits directly upstream of the parser's s_axis interface. It observes the parser's m_axis_tuser_valid.

Parameters:
- NUM_PORTS, 4, number of ingress ports (2..8).
- DATA_WIDTH, 64, AXI4-Stream data width; matches the parser.
- ID_FIFO_DEPTH, 8, frames in flight between grant and metadata; power of two.
- PORT_W, $clog2(NUM_PORTS), port ID width (derived; do not override).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  per-port data; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- s_axis_tlast  in  NUM_PORTS  per-port last.
- m_axis_tdata  out  DATA_WIDTH  to parser s_axis_tdata.
- m_axis_tvalid  out  1  to parser.
- m_axis_tready  in  1  from parser.
- m_axis_tlast  out  1  to parser.
- meta_valid  in  1  parser m_axis_tuser_valid.
- meta_port_id  out  PORT_W  source port of the metadata currently presented.
- meta_port_id_valid  out  1  meta_valid qualified by a non-empty FIFO.
- grant_port  out  PORT_W  currently granted port.
- busy  out  1  high in GRANT state.
- id_fifo_full  out  1  ID FIFO full.
- id_underflow  out  1  sticky error flag; cleared only by rst.

Behaviour:
- FSM states: IDLE and GRANT.
  - IDLE -> GRANT when any s_axis_tvalid is high and the ID FIFO is not full (a pop in the same cycle does not relax this).
  - GRANT -> IDLE on the cycle m_axis_tvalid & m_axis_tready & m_axis_tlast.
- Arbitration (IDLE only):
  - Select the first port with tvalid high, searching cyclically from last_grant+1.
  - Register the selection into grant_port, push it into the ID FIFO, and enter GRANT next cycle. Arbitration latency is 1 cycle.
  - last_grant updates when the frame's tlast beat is accepted.
  - There is a mandatory single IDLE cycle between frames.
- Datapath in GRANT (combinational, zero latency):
  - m_axis_tdata/tvalid/tlast are port[grant_port]'s signals.
  - s_axis_tready[grant_port] = m_axis_tready; all other s_axis_tready bits are 0.
- In IDLE: every s_axis_tready is 0, and m_axis_tvalid is 0.
- tvalid rising on other ports mid-frame has no effect until the frame ends.
- Metadata return:
  - meta_port_id is the FIFO head (combinational).
  - meta_port_id_valid = meta_valid & !empty. Pop on that condition.
  - meta_valid with the FIFO empty sets id_underflow, with no pop and no valid.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- FIFO:
  - Read and write pointers are PORT-independent, $clog2(ID_FIFO_DEPTH)+1 bits wide, with a wrap bit.
  - full = MSBs differ & low bits equal; empty = pointers equal.
- Reset values:
  - state IDLE, grant_port 0, last_grant NUM_PORTS-1 (port 0 wins first).
  - FIFO empty; busy 0, id_fifo_full 0, id_underflow 0, meta_port_id_valid 0, all s_axis_tready 0.
- Reset mid-frame: the frame is abandoned (downstream sees no tlast), the FIFO is flushed, and arbitration restarts from port 0. The parser is reset by the same rst.

Decomposition:
- Package eth_parser_pkg:
  - add typedef arb_state_t enum {ARB_IDLE, ARB_GRANT};
  - add constant MAX_PARSER_PORTS = 8.
- Sub-module port_id_fifo: synchronous FIFO, parameters WIDTH and DEPTH, ports push/pop/din/dout/full/empty, with registered pointers and array storage.
- Arbitration and mux logic stay in the top of this block.

Test Plan:
- Single frame: port 2 sends 3 beats, m_axis_tready=1. Required response:
  - grant_port=2 one cycle after tvalid;
  - 3 beats on m_axis with tlast on the 3rd;
  - meta_valid pulse -> meta_port_id=2, meta_port_id_valid=1.
- Fairness: all 4 ports continuously valid with 2-beat frames -> grant order 0,1,2,3,0 with exactly one IDLE cycle between frames.
- Backpressure: m_axis_tready toggled 1/0 during a 5-beat frame from port 1 -> data order preserved, only s_axis_tready[1] ever high, no extra beats.
- FIFO full: 8 frames granted with meta_valid held 0 -> id_fifo_full=1 and no 9th grant. One meta_valid then returns port ID 0, and the grant resumes the next cycle.
- Underflow: meta_valid pulse after reset with no frames -> id_underflow=1 and stays 1; meta_port_id_valid=0.
- Reset mid-frame: rst asserted on beat 2 of a port-3 frame while port 0 is also valid -> all outputs reach reset values next cycle; after deassertion port 0 is granted first.
